// File: rtl/mu_seq.sv
// mu_seq: issue/response sequencer for the pipelined multiply unit.
// Latency: MU_LAT+1 cycles from request accept to rsp_valid; one result per cycle sustained.
// Backpressure: req_ready is credit based (registered occupancy < FIFO_DEPTH); rsp side is valid/ready.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_a/req_b/req_ctl/req_rd   request from execute
//   mu_a/mu_b/mu_ctl -> mu, mu_res <- mu              multiply unit interface
//   rsp_valid/rsp_ready/rsp_data/rsp_rd               result to writeback
//   busy                            accepted-but-unpopped ops exist
// Optional: define MU_SEQ_FLUSH_EN to add a 'flush' input that discards all state.
module mu_seq #(
  parameter int MU_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MU_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_ctl,
  input  logic [TAG_W-1:0] req_rd,
  output logic [31:0]      mu_a,
  output logic [31:0]      mu_b,
  output logic [1:0]       mu_ctl,
  input  logic [31:0]      mu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] OCC_MAX = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] rd;
  } rsp_t;

  logic flush_i;
`ifdef MU_SEQ_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [CW-1:0]    occ;
  logic             accept;
  logic             pop;
  logic [MU_LAT:0]  sh_vld;
  logic [TAG_W-1:0] sh_tag [MU_LAT+1];
  rsp_t             mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_wr;
  rsp_t             head;

  // Credit counts every op from accept until writeback pops it, including
  // ops still inside mu, so the FIFO can never be written while full.
  assign req_ready = (occ < OCC_MAX) & ~flush_i;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~fifo_empty & ~flush_i;
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (occ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush_i) begin
      occ <= '0;
    end else if (accept & ~pop) begin
      occ <= occ + 1'b1;
    end else if (pop & ~accept) begin
      occ <= occ - 1'b1;
    end
  end

  // Operands idle at zero when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu_a   <= '0;
      mu_b   <= '0;
      mu_ctl <= '0;
    end else if (accept) begin
      mu_a   <= req_a;
      mu_b   <= req_b;
      mu_ctl <= req_ctl;
    end else begin
      mu_a   <= '0;
      mu_b   <= '0;
      mu_ctl <= '0;
    end
  end

  // Shadow pipeline: stage MU_LAT lines up with mu_res being valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_vld <= '0;
      for (int i = 0; i <= MU_LAT; i++) begin
        sh_tag[i] <= '0;
      end
    end else begin
      sh_vld    <= flush_i ? '0 : {sh_vld[MU_LAT-1:0], accept};
      sh_tag[0] <= req_rd;
      for (int i = 1; i <= MU_LAT; i++) begin
        sh_tag[i] <= sh_tag[i-1];
      end
    end
  end

  assign fifo_wr = sh_vld[MU_LAT] & ~flush_i;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= {mu_res, sh_tag[MU_LAT]};
    end
  end

  // Pointers wrap naturally (power-of-2 depth); full/empty disambiguate
  // the equal-pointer case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (fifo_wr & ~pop) begin
        fifo_empty <= 1'b0;
        fifo_full  <= ((wr_ptr + 1'b1) == rd_ptr);
      end else if (pop & ~fifo_wr) begin
        fifo_full  <= 1'b0;
        fifo_empty <= ((rd_ptr + 1'b1) == wr_ptr);
      end
    end
  end

  assign head     = mem[rd_ptr];
  assign rsp_data = fifo_empty ? '0 : head.data;
  assign rsp_rd   = fifo_empty ? '0 : head.rd;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fifo_wr && fifo_full));
    end
  end
`endif

endmodule

// File: tb/tb_mu_seq.sv
module tb_mu_seq;
  localparam int MU_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [1:0] req_ctl = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic [31:0] mu_a, mu_b, mu_res;
  logic [1:0] mu_ctl;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [TAG_W-1:0] rsp_rd;
  logic busy;

  int total = 0;
  int bad = 0;

  mu_seq #(.MU_LAT(MU_LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MU_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_ctl(req_ctl), .req_rd(req_rd), .mu_a(mu_a), .mu_b(mu_b), .mu_ctl(mu_ctl),
    .mu_res(mu_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] c);
    logic [63:0] xa, xb, p;
    xa = (c == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    xb = (c == 2'b00 || c == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = xa * xb;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiply unit: MU_LAT register stages after operand capture.
  logic [31:0] mu_pipe [MU_LAT];
  always @(posedge clk) begin
    mu_pipe[0] <= mul_ref(mu_a, mu_b, mu_ctl);
    for (int i = 1; i < MU_LAT; i++) mu_pipe[i] <= mu_pipe[i-1];
  end
  assign mu_res = mu_pipe[MU_LAT-1];

  // Reference model: in-order queue of outstanding ops, each visible at
  // the writeback side from a known cycle onwards; credit = queue length.
  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] rd;
    int               rdy;
  } ent_t;
  ent_t q[$];
  int occ_m = 0;
  int cyc = 0;
  logic acc_n = 0, pop_n = 0, fl_n = 0;
  logic [31:0] s_a, s_b, e_a = 0, e_b = 0;
  logic [1:0] s_c, e_c = 0;
  logic [TAG_W-1:0] s_rd;

  always @(negedge rst_n) begin
    q.delete();
    occ_m = 0; acc_n = 0; pop_n = 0; fl_n = 0;
    e_a = 0; e_b = 0; e_c = 0;
  end

  always @(negedge clk) begin
    logic ev, head_rdy;
    if (!rst_n) begin
      chk("rst_rvld", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mua", mu_a, 0);
      chk("rst_rdy", req_ready, 1);
      acc_n = 0; pop_n = 0; fl_n = 0;
    end else begin
      fl_n = flush;
      head_rdy = (q.size() > 0) ? (q[0].rdy <= cyc) : 1'b0;
      ev = head_rdy && !fl_n;
      chk("rdy", req_ready, (occ_m < DEPTH) && !fl_n);
      chk("busy", busy, occ_m != 0);
      chk("rvld", rsp_valid, ev);
      if (ev) begin
        chk("rdata", rsp_data, q[0].data);
        chk("rrd", rsp_rd, q[0].rd);
      end else if (!fl_n) begin
        chk("rdata0", rsp_data, 0);
        chk("rrd0", rsp_rd, 0);
      end
      chk("mu_a", mu_a, e_a);
      chk("mu_b", mu_b, e_b);
      chk("mu_ctl", mu_ctl, e_c);
      acc_n = req_valid && (occ_m < DEPTH) && !fl_n;
      pop_n = ev && rsp_ready;
      s_a = req_a; s_b = req_b; s_c = req_ctl; s_rd = req_rd;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (fl_n) begin
        q.delete();
        occ_m = 0;
        e_a = 0; e_b = 0; e_c = 0;
      end else begin
        if (pop_n) void'(q.pop_front());
        if (acc_n) q.push_back('{mul_ref(s_a, s_b, s_c), s_rd, cyc + MU_LAT + 1});
        occ_m = occ_m + int'(acc_n) - int'(pop_n);
        e_a = acc_n ? s_a : 0;
        e_b = acc_n ? s_b : 0;
        e_c = acc_n ? s_c : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c, input logic [TAG_W-1:0] rd);
    req_valid = v; req_a = a; req_b = b; req_ctl = c; req_rd = rd;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("wait_rsp", rsp_valid, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n, acc, seen;
    repeat (3) step();
    chk("init_rvld", rsp_valid, 0);
    chk("init_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy", req_ready, 1);

    // Single MUL, latency measurement
    rsp_ready = 1'b1;
    set_req(1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 2'b00, 7);
    step();
    req_valid = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!rsp_valid && n < 10);
    chk("lat", n, MU_LAT + 1);
    chk("mul12", rsp_data, 12);
    chk("mul_rd", rsp_rd, 7);
    repeat (3) step();

    // Back-to-back high-half variants
    set_req(1, 32'h8000_0000, 32'h8000_0000, 2'b01, 1); step();
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2); step();
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 3); step();
    req_valid = 0;
    wait_rsp();
    chk("mulh", rsp_data, 32'h4000_0000); chk("mulh_rd", rsp_rd, 1); step();
    chk("mulhsu_v", rsp_valid, 1);
    chk("mulhsu", rsp_data, 32'hFFFF_FFFF); chk("mulhsu_rd", rsp_rd, 2); step();
    chk("mulhu_v", rsp_valid, 1);
    chk("mulhu", rsp_data, 32'hFFFF_FFFE); chk("mulhu_rd", rsp_rd, 3); step();
    chk("b2b_empty", rsp_valid, 0);

    // Backpressure: only DEPTH of 6 offers accepted
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1, 32'(i + 2), 32'(i + 10), 2'b00, TAG_W'(i + 8));
      acc += int'(req_ready);
      step();
    end
    req_valid = 0;
    chk("bp_acc", acc, DEPTH);
    step();
    chk("bp_full_rdy", req_ready, 0);
    chk("bp_busy", busy, 1);
    repeat (MU_LAT + 2) step();
    rsp_ready = 1'b1;
    chk("bp_rdy_prepop", req_ready, 0);
    step();
    chk("bp_rdy_postpop", req_ready, 1);
    repeat (5) step();
    chk("bp_drained", busy, 0);

    // Accept+pop at full is refused; at occ=2 it is a wash
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1, 32'(i + 100), 32'(3), 2'b00, TAG_W'(i + 20));
      step();
    end
    req_valid = 0;
    repeat (MU_LAT + 2) step();
    set_req(1, 32'd77, 32'd77, 2'b00, 31);
    rsp_ready = 1'b1;
    chk("full_pop_rdy", req_ready, 0);
    step();
    req_valid = 0;
    step();
    set_req(1, 32'd9, 32'd9, 2'b00, 30);
    step();
    req_valid = 0;
    rsp_ready = 1'b0;
    chk("occ2_busy", busy, 1);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      set_req(1, 32'(i + 1), 32'(5), 2'b01, TAG_W'(i));
      acc += int'(req_ready);
      step();
    end
    req_valid = 0;
    chk("occ2_credit", acc, 2);
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("occ2_drained", busy, 0);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      set_req(1, 32'(i + 40), 32'(i + 50), 2'b00, TAG_W'(i + 4));
      step();
    end
    req_valid = 0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvld", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mua", mu_a, 0);
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      seen += int'(rsp_valid);
    end
    chk("no_stale", seen, 0);

`ifdef MU_SEQ_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      set_req(1, 32'(i + 60), 32'(i + 70), 2'b00, TAG_W'(i + 12));
      step();
    end
    req_valid = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_rdy", req_ready, 1);
    seen = 0;
    repeat (8) begin
      step();
      seen += int'(rsp_valid);
    end
    chk("fl_no_rsp", seen, 0);
    set_req(1, 32'd5, 32'd6, 2'b00, 9);
    step();
    req_valid = 0;
    wait_rsp();
    chk("fl_mul30", rsp_data, 30);
    chk("fl_rd", rsp_rd, 9);
    repeat (4) step();
`endif

    // Randomized traffic against the queue model
    repeat (500) begin
      set_req($urandom_range(2, 0) != 0, $urandom, $urandom, 2'($urandom_range(3, 0)),
              TAG_W'($urandom_range(31, 0)));
      rsp_ready = ($urandom_range(3, 0) != 0);
`ifdef MU_SEQ_FLUSH_EN
      flush = ($urandom_range(63, 0) == 0);
`endif
      step();
    end
    req_valid = 0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    repeat (15) step();
    chk("rand_drained", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
